// File: rtl/ux607_regvec_wr_ctrl_if.sv
// rtl/ux607_regvec_wr_ctrl_if.sv - request/response handshake bundle for the register-vector write sequencer
interface ux607_regvec_wr_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [WIDTH-1:0]   req_wdata;
    logic [WIDTH/8-1:0] req_mask;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_op, req_wdata, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_wdata, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ux607_regvec_wr_ctrl.sv
// rtl/ux607_regvec_wr_ctrl.sv - masked write / atomic bit-op sequencer in front of a register vector
module ux607_regvec_wr_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    ux607_regvec_wr_ctrl_if.slave        bus,
    input  logic [WIDTH-1:0]             reg_q,
    output logic [WIDTH-1:0]             reg_d,
    output logic                         reg_en
);
    localparam int LANES = WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_SET    = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_TOGGLE = 2'd3;

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [LANES-1:0]   mask_q;
    logic               en_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   rdata_q;
    logic [WIDTH-1:0]   merged;
    logic               req_fire;

    // req_ready only follows rsp_ready while a response is pending; never req_valid
    assign bus.req_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign reg_en        = en_q;
    assign reg_d         = en_q ? merged : reg_q;

    always_comb begin
        merged = reg_q;
        for (int i = 0; i < LANES; i++) begin
            if (mask_q[i]) begin
                case (op_q)
                    OP_WRITE:  merged[8*i +: 8] = wdata_q[8*i +: 8];
                    OP_SET:    merged[8*i +: 8] = reg_q[8*i +: 8] | wdata_q[8*i +: 8];
                    OP_CLEAR:  merged[8*i +: 8] = reg_q[8*i +: 8] & ~wdata_q[8*i +: 8];
                    OP_TOGGLE: merged[8*i +: 8] = reg_q[8*i +: 8] ^ wdata_q[8*i +: 8];
                    default:   merged[8*i +: 8] = reg_q[8*i +: 8];
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op_q        <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        op_q    <= bus.req_op;
                        wdata_q <= bus.req_wdata;
                        mask_q  <= bus.req_mask;
                        en_q    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Pre-update value; the register itself loads reg_d on this same edge
                    rdata_q     <= reg_q;
                    en_q        <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (req_fire) begin
                            op_q    <= bus.req_op;
                            wdata_q <= bus.req_wdata;
                            mask_q  <= bus.req_mask;
                            en_q    <= 1'b1;
                            state   <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    en_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ux607_regvec_wr_ctrl.sv
// tb/tb_ux607_regvec_wr_ctrl.sv - directed bench with a register-vector model behind the sequencer
module tb_ux607_regvec_wr_ctrl;
    logic        clock;
    logic        reset_n;
    logic [31:0] regv;
    logic [31:0] reg_d;
    logic        reg_en;
    logic        preset;
    logic [31:0] preset_val;
    int          checks;
    int          errors;

    ux607_regvec_wr_ctrl_if #(.WIDTH(32)) bus ();

    ux607_regvec_wr_ctrl #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .reg_q   (regv),
        .reg_d   (reg_d),
        .reg_en  (reg_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register vector model; preset lets the bench seed reg_q between transactions
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      regv <= '0;
        else if (preset)   regv <= preset_val;
        else if (reg_en)   regv <= reg_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic seed(input logic [31:0] v);
        preset_val = v;
        preset     = 1'b1;
        tick();
        preset     = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [1:0] op, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [31:0] q_pre, input logic [31:0] exp_d);
        seed(q_pre);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_wdata = wdata;
        bus.req_mask  = mask;
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "_idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk({tag, "_exec_en"}, {31'd0, reg_en}, 32'd1);
        chk({tag, "_exec_d"}, reg_d, exp_d);
        chk({tag, "_exec_ready"}, {31'd0, bus.req_ready}, 32'd0);
        chk({tag, "_exec_rspv"}, {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk({tag, "_resp_en"}, {31'd0, reg_en}, 32'd0);
        chk({tag, "_resp_v"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_resp_rdata"}, bus.rsp_rdata, q_pre);
        chk({tag, "_reg_new"}, regv, exp_d);
        tick();
        chk({tag, "_done_v"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        preset        = 1'b0;
        preset_val    = '0;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_wdata = '0;
        bus.req_mask  = '0;
        bus.rsp_ready = 1'b1;

        tick();
        tick();
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_en", {31'd0, reg_en}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_d", reg_d, regv);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post_rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
        chk("post_rst_en", {31'd0, reg_en}, 32'd0);

        txn("write",  2'd0, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 32'hDEAD_BEEF);
        txn("set",    2'd1, 32'h0F0F_0F0F, 4'h5, 32'hF0F0_F0F0, 32'hF0FF_F0FF);
        txn("clear",  2'd2, 32'hFFFF_FFFF, 4'h5, 32'hF0F0_F0F0, 32'hF000_F000);
        txn("toggle", 2'd3, 32'hFFFF_FFFF, 4'h5, 32'hF0F0_F0F0, 32'hF00F_F00F);
        txn("mask0",  2'd0, 32'hFFFF_FFFF, 4'h0, 32'hAAAA_5555, 32'hAAAA_5555);

        // Back-to-back: set 0x1 then toggle 0x3, second accepted on first rsp handshake
        seed(32'h0);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd1;
        bus.req_wdata = 32'h1;
        bus.req_mask  = 4'hF;
        tick();
        bus.req_op    = 2'd3;
        bus.req_wdata = 32'h3;
        #1;
        chk("b2b_exec1_d", reg_d, 32'h1);
        chk("b2b_exec1_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        chk("b2b_resp1_rdata", bus.rsp_rdata, 32'h0);
        chk("b2b_resp1_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("b2b_reg1", regv, 32'h1);
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk("b2b_exec2_en", {31'd0, reg_en}, 32'd1);
        chk("b2b_exec2_d", reg_d, 32'h2);
        chk("b2b_exec2_rspv", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk("b2b_resp2_rdata", bus.rsp_rdata, 32'h1);
        chk("b2b_resp2_v", {31'd0, bus.rsp_valid}, 32'd1);
        chk("b2b_reg2", regv, 32'h2);
        tick();
        chk("b2b_done_v", {31'd0, bus.rsp_valid}, 32'd0);

        // Backpressure with a second request waiting
        seed(32'h1111_1111);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_wdata = 32'h2222_2222;
        bus.req_mask  = 4'hF;
        tick();
        bus.req_op    = 2'd1;
        bus.req_wdata = 32'h0000_000F;
        bus.req_mask  = 4'h1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rdata", bus.rsp_rdata, 32'h1111_1111);
            chk("bp_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_en", {31'd0, reg_en}, 32'd0);
            chk("bp_reg", regv, 32'h2222_2222);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        #1;
        chk("bp_exec2_en", {31'd0, reg_en}, 32'd1);
        chk("bp_exec2_d", reg_d, 32'h2222_222F);
        tick();
        chk("bp_resp2_rdata", bus.rsp_rdata, 32'h2222_2222);
        tick();
        chk("bp_done_v", {31'd0, bus.rsp_valid}, 32'd0);

        // Reset during EXEC
        seed(32'h5A5A_5A5A);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_wdata = 32'h0;
        bus.req_mask  = 4'hF;
        tick();
        bus.req_valid = 1'b0;
        chk("rexec_en_before", {31'd0, reg_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rexec_en_async", {31'd0, reg_en}, 32'd0);
        chk("rexec_ready_async", {31'd0, bus.req_ready}, 32'd1);
        chk("rexec_rspv_async", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rexec_rdata_async", bus.rsp_rdata, 32'd0);
        tick();
        reset_n       = 1'b1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rexec_idle_rspv", {31'd0, bus.rsp_valid}, 32'd0);
            chk("rexec_idle_ready", {31'd0, bus.req_ready}, 32'd1);
            chk("rexec_idle_en", {31'd0, reg_en}, 32'd0);
            chk("rexec_idle_d", reg_d, regv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ux607_regvec_wr_ctrl.md
# ux607_regvec_wr_ctrl

Write sequencer that sits directly upstream of a 32-bit asynchronous-reset register vector in the ux607 peripheral space. It accepts masked write and atomic bit-operation requests over a valid/ready channel. It computes the merged next value from the register's current output and pulses the register's data/enable inputs for exactly one cycle. It then returns the pre-update register value on a valid/ready response channel.

## Interface
- WIDTH, 32: register width; must be a multiple of 8.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset; assertion clears all state immediately; release synchronous to clock.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_op  in  2  operation: 0 write, 1 set, 2 clear, 3 toggle.
- req_wdata  in  WIDTH  operand.
- req_mask  in  WIDTH/8  byte-lane enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  WIDTH  register value before the update.
- reg_q  in  WIDTH  current register-vector output.
- reg_d  out  WIDTH  next value to the register vector.
- reg_en  out  1  register-vector load enable; one-cycle pulse.

## Operation
- Three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On handshake, capture op, wdata and mask into internal registers, then go to EXEC.
- EXEC (always exactly one cycle):
  - reg_en=1.
  - reg_d = merge(reg_q, captured op/wdata/mask).
  - rsp_rdata register loads reg_q.
  - Next state is RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1.
  - rsp_rdata is held stable until the handshake.
  - req_ready = rsp_ready.
  - On rsp handshake with a simultaneous req handshake: capture the new request and go to EXEC.
  - On rsp handshake without a req handshake: go to IDLE.
  - Without an rsp handshake: stay in RESP.
- Merge rule for byte lane i, with mask[i]=1:
  - write: wdata.
  - set: q|wdata.
  - clear: q&~wdata.
  - toggle: q^wdata.
- Merge rule for byte lane i, with mask[i]=0: q unchanged.
- Merge is bitwise per lane, with no carries or width growth.
- Outside EXEC: reg_d=reg_q and reg_en=0. The register never changes value except in EXEC.
- Mask all-zero is still a full transaction: reg_en pulses, reg_d=reg_q, and a response is returned.
- Hazard freedom: each EXEC samples reg_q after the previous EXEC's update has landed. Back-to-back requests therefore observe each other's results.
- rsp_valid and req_ready never depend combinationally on req_valid. req_ready depends combinationally on rsp_ready only in RESP.

## Timing
- Reset values:
  - state IDLE.
  - req_ready=1.
  - rsp_valid=0.
  - rsp_rdata=0.
  - reg_en=0.
  - reg_d=reg_q.
  - captured op/wdata/mask all 0.
- Latency from req handshake in cycle N:
  - reg_en high in N+1.
  - Register shows the new value in N+2.
  - rsp_valid high from N+2.
- Throughput: one transaction per 2 cycles when rsp_ready is held high.
- Reset asserted mid-transaction:
  - Pending request is dropped with no reg_en pulse.
  - Pending response is lost.
  - Outputs take reset values asynchronously.
- rsp_ready low stalls in RESP indefinitely. No further reg_en pulses occur and req_ready stays 0.

## Test plan
- Reset held, then released with reg_q=0x0000_0000 → req_ready=1, rsp_valid=0, reg_en=0, rsp_rdata=0.
- Write: wdata=0xDEAD_BEEF, mask=0xF, reg_q=0x1234_5678 → one-cycle reg_en with reg_d=0xDEAD_BEEF; response rsp_rdata=0x1234_5678 two cycles after acceptance.
- Set, clear and toggle with mask=0x5 (lanes 0 and 2), reg_q=0xF0F0_F0F0:
  - set 0x0F0F_0F0F → reg_d=0xF0FF_F0FF.
  - clear 0xFFFF_FFFF → reg_d=0xF000_F000.
  - toggle 0xFFFF_FFFF → reg_d=0xF00F_F00F.
- Back-to-back, rsp_ready=1 throughout:
  - Sequence from reg_q=0x0000_0000: set 0x1, then toggle 0x3 (mask 0xF each).
  - Second EXEC sees reg_q=0x0000_0001 and drives reg_d=0x0000_0002.
  - Responses are 0x0, then 0x1.
  - Second request is accepted in the same cycle as the first rsp handshake.
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 → rsp_valid and rsp_rdata stable, req_ready=0, no extra reg_en; completes on rsp_ready=1.
- Mask=0x0 write of 0xFFFF_FFFF with reg_q=0xAAAA_5555 → reg_en pulse with reg_d=0xAAAA_5555, rsp_rdata=0xAAAA_5555.
- reset_n asserted in the EXEC cycle → reg_en drops immediately, rsp_valid never rises, and the bench sees IDLE state after release.
